// File: rtl/rx_trama_pkg.sv
// Shared types and constants for the rx_trama_max serial receiver.
// State encoding, oversampling default, control-bit positions and tick divisor helper.
package rx_trama_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int CTRL_TOTAL_BIT = 1;
  localparam int CTRL_ACT_BIT   = 4;

  // Truncating divide, floored at 2 so the tick never degenerates into a constant.
  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/gen_tick_baud.sv
// Free-running divider: one-cycle tick every DIVISOR clocks.
// Latency: first tick DIVISOR clocks after reset; no backpressure, always running.
// Backpressure: none; consumers sample the tick as an enable.
module gen_tick_baud #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIVISOR - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_trama_max.sv
// 8N1 (8E1 with RX_PARITY_EN) UART receiver, 16x oversampled, holding remote control bits.
// Latency: pulse 1 clk after the mid-stop-bit sample (~9.5 bit times + 2 sync clk after start edge).
// Backpressure: none; each byte is offered once with a single-cycle rx_valid strobe.
module rx_trama_max
  import rx_trama_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 1200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic       ctrl_total,
  output logic       ctrl_activacion
);

  localparam int DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);

  logic       rx_meta, rx_s;
  logic       tick;
  state_t     state, state_nxt;
  logic [3:0] sample_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       bit_tick, shift_en, stop_tick;
  logic       do_valid, do_ferr, do_perr;
`ifdef RX_PARITY_EN
  logic       par_bit;
  logic       par_ok;
`endif

  gen_tick_baud #(.DIVISOR(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // State register; sample_cnt restarts on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        sample_cnt <= '0;
      else if (tick)
        sample_cnt <= sample_cnt + 4'd1;
    end
  end

  assign bit_tick = tick && (sample_cnt == 4'd15);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (tick && sample_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (bit_tick && bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
      PARITY: if (bit_tick) state_nxt = STOP;
      STOP:   if (bit_tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state == DATA) && bit_tick;
    stop_tick = (state == STOP) && bit_tick;
    do_ferr   = stop_tick && !rx_s;
`ifdef RX_PARITY_EN
    par_ok    = ~^{shift_reg, par_bit};
    do_valid  = stop_tick && rx_s && par_ok;
    do_perr   = stop_tick && rx_s && !par_ok;
`else
    do_valid  = stop_tick && rx_s;
    do_perr   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_valid   <= do_valid;
      frame_err  <= do_ferr;
      parity_err <= do_perr;
      if (state != DATA)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;
      if (shift_en)
        shift_reg <= {rx_s, shift_reg[7:1]};
      if (do_valid)
        rx_data <= shift_reg;
`ifdef RX_PARITY_EN
      if (state == PARITY && bit_tick)
        par_bit <= rx_s;
`endif
    end
  end

  assign busy            = (state != IDLE);
  assign ctrl_total      = rx_data[CTRL_TOTAL_BIT];
  assign ctrl_activacion = rx_data[CTRL_ACT_BIT];

endmodule
